ack_bus_scheduler: RTL

ACK_BUS_SCHEDULER -- requirements
Module: ack_bus_scheduler

---
 rtl/ack_bus_scheduler_pkg.sv | 15 +
 rtl/ack_bus_scheduler_rr_pick4.sv | 28 ++
 rtl/ack_bus_scheduler.sv | 111 +++++++++++
 3 files changed

// File: rtl/ack_bus_scheduler_pkg.sv
// rtl/ack_bus_scheduler_pkg.sv - shared source IDs and FSM encoding for the ack bus scheduler
package ack_bus_scheduler_pkg;

   localparam logic [1:0] SRC_MEM  = 2'b00;
   localparam logic [1:0] SRC_SHA  = 2'b01;
   localparam logic [1:0] SRC_AES  = 2'b10;
   localparam logic [1:0] SRC_CTRL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/ack_bus_scheduler_rr_pick4.sv
// rtl/ack_bus_scheduler_rr_pick4.sv - combinational round-robin picker over four sources
module rr_pick4
   import ack_bus_scheduler_pkg::*;
(
   input  logic [3:0] pending_i,
   input  logic [1:0] last_winner_i,
   output logic [1:0] winner_o,
   output logic       any_o
);

   logic [1:0] cand;

   // Walk IDs downward from last_winner-1 (wrapping mod 4); first pending source wins,
   // so the previous winner is considered last.
   always_comb begin
      winner_o = SRC_CTRL;
      any_o    = 1'b0;
      cand     = last_winner_i;
      for (int k = 0; k < 4; k++) begin
         cand = last_winner_i - 2'(k + 1);
         if (!any_o && pending_i[cand]) begin
            winner_o = cand;
            any_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ack_bus_scheduler.sv
// rtl/ack_bus_scheduler.sv - round-robin scheduler retiring completion acks onto a shared bus
module ack_bus_scheduler
   import ack_bus_scheduler_pkg::*;
#(
   parameter int unsigned ACK_HOLD = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       done_mem,
   input  logic       done_sha,
   input  logic       done_aes,
   input  logic       done_ctrl,
   output logic       ack_valid_n,
   output logic [1:0] ack_id,
   output logic       ack_ready_mem,
   output logic       ack_ready_sha,
   output logic       ack_ready_aes,
   output logic       ack_ready_ctrl,
   output logic [3:0] pending,
   output logic [3:0] overflow,
   output logic       busy
);

   state_e     state_q, state_d;
   logic [3:0] pending_q, pending_d;
   logic [3:0] overflow_q, overflow_d;
   logic [1:0] last_q, last_d;      // last winner; doubles as the ID driven during GRANT
   logic [2:0] cnt_q, cnt_d;        // remaining GRANT cycles after the current one
   logic [1:0] pick;
   logic       pick_any;
   logic       retire;
   logic [3:0] ack_ready;
   logic [3:0] done_vec;
   logic [3:0] clr;

   assign done_vec = {done_ctrl, done_aes, done_sha, done_mem};

   rr_pick4 u_pick (
      .pending_i     (pending_q),
      .last_winner_i (last_q),
      .winner_o      (pick),
      .any_o         (pick_any)
   );

   // FSM next state and bus outputs; the bus idles at valid_n=1 / id=11 outside GRANT.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      retire      = 1'b0;
      ack_valid_n = 1'b1;
      ack_id      = SRC_CTRL;
      ack_ready   = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            if (en && pick_any) begin
               state_d = ST_GRANT;
               last_d  = pick;
               cnt_d   = 3'(ACK_HOLD - 1);
            end
         end
         ST_GRANT: begin
            ack_valid_n = 1'b0;
            ack_id      = last_q;
            if (cnt_q == 3'd0) begin
               retire    = 1'b1;
               ack_ready = 4'b0001 << last_q;
               state_d   = ST_GAP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pending/overflow update; a done for the winner on its retire edge is a fresh request.
   always_comb begin
      clr        = retire ? (4'b0001 << last_q) : 4'b0000;
      pending_d  = (pending_q & ~clr) | done_vec;
      overflow_d = overflow_q | (done_vec & pending_q & ~clr);
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pending_q  <= 4'b0000;
         overflow_q <= 4'b0000;
         last_q     <= SRC_MEM;
         cnt_q      <= 3'd0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ack_ready_mem  = ack_ready[0];
   assign ack_ready_sha  = ack_ready[1];
   assign ack_ready_aes  = ack_ready[2];
   assign ack_ready_ctrl = ack_ready[3];
   assign pending        = pending_q;
   assign overflow       = overflow_q;
   assign busy           = (state_q != ST_IDLE);

endmodule
